imm_materializer: RTL



---
 rtl/imm_materializer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/imm_materializer.sv
// imm_materializer: expands li rd,imm into a stream of RV64I instruction words.
// Optional IMM_MATERIALIZER_COMPACT_EN drops zero chunks from the 64-bit tail and merges their shifts.
module imm_materializer (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] req_imm_i,
    input  logic [4:0]  req_rd_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic        inst_last_o,
    output logic        busy_o
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] HI_LUI  = 4'd1;
    localparam logic [3:0] HI_ADDI = 4'd2;
    localparam logic [3:0] SH1     = 4'd3;
    localparam logic [3:0] AD1     = 4'd4;
    localparam logic [3:0] SH2     = 4'd5;
    localparam logic [3:0] AD2     = 4'd6;
    localparam logic [3:0] SH3     = 4'd7;
    localparam logic [3:0] AD3     = 4'd8;
    localparam logic [3:0] SHF     = 4'd9;

    logic [3:0]  state, cur, ns;
    logic [63:0] imm_r, src_imm;
    logic [4:0]  rd_r, src_rd;
    logic [31:0] nw;
    logic        nl;

    function automatic logic fits32(input logic [63:0] x);
        return &x[63:31] | ~|x[63:31];
    endfunction

    function automatic logic [31:0] val32(input logic [63:0] x);
        return fits32(x) ? x[31:0] : x[63:32];
    endfunction

    function automatic logic fits12(input logic [31:0] v);
        return &v[31:11] | ~|v[31:11];
    endfunction

    // Total shift applied after the H part once chunk k has been placed.
    function automatic logic [5:0] cum(input logic [1:0] k);
        return k == 2'd0 ? 6'd0 : k == 2'd1 ? 6'd11 : k == 2'd2 ? 6'd22 : 6'd32;
    endfunction

    // Chunk index the next shift starts from, given the word just emitted.
    function automatic logic [1:0] pos(input logic [3:0] s);
        return s == AD1 ? 2'd2 : s == AD2 ? 2'd3 : 2'd1;
    endfunction

    function automatic logic [3:0] nxt(input logic [3:0] s, input logic [63:0] x);
        logic [31:0] v;
        logic [1:0]  p;
        logic [3:0]  t;
        v = val32(x);
        p = pos(s);
`ifdef IMM_MATERIALIZER_COMPACT_EN
        t = (p == 2'd1 && |x[31:21]) ? SH1 : (p != 2'd3 && |x[20:10]) ? SH2 : |x[9:0] ? SH3 : SHF;
`else
        t = p == 2'd1 ? SH1 : p == 2'd2 ? SH2 : SH3;
`endif
        case (s)
            IDLE:     return fits12(v) ? HI_ADDI : HI_LUI;
            HI_LUI:   return v[11:0] != 12'd0 ? HI_ADDI : fits32(x) ? IDLE : t;
            HI_ADDI:  return fits32(x) ? IDLE : t;
            SH1:      return AD1;
            SH2:      return AD2;
            SH3:      return AD3;
            AD1, AD2: return t;
            default:  return IDLE;
        endcase
    endfunction

    function automatic logic [31:0] enc(input logic [3:0] s, input logic [3:0] prev,
                                        input logic [63:0] x, input logic [4:0] rd);
        logic [31:0] v;
        logic [19:0] hi;
        logic [1:0]  j;
        logic [5:0]  sh;
        v  = val32(x);
        hi = v[31:12] + {19'd0, v[11]};
        j  = s == SH1 ? 2'd1 : s == SH2 ? 2'd2 : 2'd3;
        sh = cum(j) - cum(pos(prev) - 2'd1);
        case (s)
            HI_LUI:  return {hi, rd, 7'h37};
            HI_ADDI: return fits12(v) ? {v[11:0], 5'd0, 3'd0, rd, 7'h13} : {v[11:0], rd, 3'd0, rd, 7'h1B};
            AD1:     return {1'b0, x[31:21], rd, 3'd0, rd, 7'h13};
            AD2:     return {1'b0, x[20:10], rd, 3'd0, rd, 7'h13};
            AD3:     return {2'b0, x[9:0], rd, 3'd0, rd, 7'h13};
            SH1, SH2, SH3, SHF: return {6'd0, sh, rd, 3'b001, rd, 7'h13};
            default: return 32'd0;
        endcase
    endfunction

    // In IDLE the next word comes straight from the request so it is valid one cycle after accept.
    always_comb begin
        cur     = req_ready_o ? IDLE : state;
        src_rd  = req_ready_o ? req_rd_i : rd_r;
        src_imm = req_ready_o ? (req_rd_i == 5'd0 ? 64'd0 : req_imm_i) : imm_r;
        ns      = nxt(cur, src_imm);
        nw      = enc(ns, cur, src_imm, src_rd);
        nl      = nxt(ns, src_imm) == IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            inst_valid_o <= 1'b0;
            inst_o       <= 32'd0;
            inst_last_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else if ((req_valid_i && req_ready_o) || (inst_valid_o && inst_ready_i)) begin
            state        <= ns;
            inst_o       <= nw;
            inst_last_o  <= nl;
            inst_valid_o <= ns != IDLE;
            busy_o       <= ns != IDLE;
            req_ready_o  <= ns == IDLE;
            if (req_ready_o) begin
                imm_r <= src_imm;
                rd_r  <= src_rd;
            end
        end
    end
endmodule
